// File: rtl/multicycle_sequencer_pkg.sv
// Shared definitions for the multi-cycle RV32I control sequencer:
// state encoding, PC source selects and the opcode field constants.
package multicycle_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_HALT   = 3'd6
  } state_e;

  localparam logic [1:0] PC_SRC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_SRC_IMM   = 2'b01;
  localparam logic [1:0] PC_SRC_JALR  = 2'b10;

  localparam logic [4:0] OPCODE_LOAD    = 5'b00000;
  localparam logic [4:0] OPCODE_ARITH_I = 5'b00100;
  localparam logic [4:0] OPCODE_AUIPC   = 5'b00101;
  localparam logic [4:0] OPCODE_STORE   = 5'b01000;
  localparam logic [4:0] OPCODE_ARITH_R = 5'b01100;
  localparam logic [4:0] OPCODE_LUI     = 5'b01101;
  localparam logic [4:0] OPCODE_BRANCH  = 5'b11000;
  localparam logic [4:0] OPCODE_JALR    = 5'b11001;
  localparam logic [4:0] OPCODE_JAL     = 5'b11011;
  localparam logic [4:0] OPCODE_SYSTEM  = 5'b11100;

  // Instructions whose result is written to the register file in WB.
  function automatic logic is_writeback_op(input logic [4:0] op);
    return (op == OPCODE_ARITH_R) || (op == OPCODE_ARITH_I) ||
           (op == OPCODE_LUI)     || (op == OPCODE_AUIPC)   ||
           (op == OPCODE_JAL)     || (op == OPCODE_JALR);
  endfunction

endpackage

// File: rtl/multicycle_sequencer_mem_watchdog.sv
// Memory-wait watchdog: counts stalled request cycles and flags the one
// that would bring the count to all-ones.
module mem_watchdog #(
  parameter int TIMEOUT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic waiting,
  output logic expired
);

  // Terminal cycle: the waiting cycle that takes the count to all-ones.
  localparam logic [TIMEOUT_W-1:0] TERMINAL = {TIMEOUT_W{1'b1}} - TIMEOUT_W'(1);

  logic [TIMEOUT_W-1:0] count_q, count_d;

  assign expired = waiting && (count_q == TERMINAL);

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (waiting) begin
      count_d = count_q + TIMEOUT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB, shares one memory port and gates the write strobes.
module multicycle_sequencer
  import multicycle_sequencer_pkg::*;
#(
  parameter int TIMEOUT_W = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [4:0]  opcode,
  input  logic        branch_taken,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_sel,
  output logic        mem_we,
  output logic        ir_load,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        reg_we,
  output logic        illegal,
  output logic        bus_err,
  output logic        halted,
  output logic [31:0] instret
);

  state_e      state_q, state_d;
  logic [4:0]  op_q, op_d;
  logic [31:0] instret_q, instret_d;
  logic        bus_err_q, bus_err_d;
  logic        armed_q, armed_d;
  logic        retire;
  logic        wd_clear, wd_waiting, wd_expired;

  assign wd_waiting = mem_req && !mem_ready;
  assign wd_clear   = (mem_req && mem_ready) || (state_d != state_q);

  mem_watchdog #(
    .TIMEOUT_W (TIMEOUT_W)
  ) u_mem_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (wd_clear),
    .waiting (wd_waiting),
    .expired (wd_expired)
  );

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    bus_err_d = bus_err_q;
    armed_d   = 1'b1;
    mem_req   = 1'b0;
    mem_sel   = 1'b0;
    mem_we    = 1'b0;
    ir_load   = 1'b0;
    pc_we     = 1'b0;
    pc_src    = PC_SRC_PLUS4;
    reg_we    = 1'b0;
    illegal   = 1'b0;
    retire    = 1'b0;

    unique case (state_q)
      // armed_q holds IDLE for one full clock after reset release
      ST_IDLE: begin
        if (armed_q) state_d = ST_FETCH;
      end
      ST_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_load = 1'b1;
          state_d = ST_DECODE;
        end else if (wd_expired) begin
          bus_err_d = 1'b1;
          state_d   = ST_HALT;
        end
      end
      ST_DECODE: begin
        op_d    = opcode;
        state_d = (opcode == OPCODE_SYSTEM) ? ST_HALT : ST_EXEC;
      end
      ST_EXEC: begin
        if ((op_q == OPCODE_LOAD) || (op_q == OPCODE_STORE)) begin
          state_d = ST_MEM;
        end else if (op_q == OPCODE_BRANCH) begin
          pc_we   = 1'b1;
          pc_src  = branch_taken ? PC_SRC_IMM : PC_SRC_PLUS4;
          retire  = 1'b1;
          state_d = ST_FETCH;
        end else if (is_writeback_op(op_q)) begin
          state_d = ST_WB;
        end else begin
          illegal = 1'b1;
          pc_we   = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_MEM: begin
        mem_req = 1'b1;
        mem_sel = 1'b1;
        mem_we  = (op_q == OPCODE_STORE);
        if (mem_ready) begin
          if (op_q == OPCODE_STORE) begin
            pc_we   = 1'b1;
            retire  = 1'b1;
            state_d = ST_FETCH;
          end else begin
            state_d = ST_WB;
          end
        end else if (wd_expired) begin
          bus_err_d = 1'b1;
          state_d   = ST_HALT;
        end
      end
      ST_WB: begin
        reg_we  = 1'b1;
        pc_we   = 1'b1;
        retire  = 1'b1;
        state_d = ST_FETCH;
        if (op_q == OPCODE_JAL)       pc_src = PC_SRC_IMM;
        else if (op_q == OPCODE_JALR) pc_src = PC_SRC_JALR;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    instret_d = instret_q + {31'd0, retire};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      op_q      <= 5'd0;
      instret_q <= 32'd0;
      bus_err_q <= 1'b0;
      armed_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      instret_q <= instret_d;
      bus_err_q <= bus_err_d;
      armed_q   <= armed_d;
    end
  end

  assign bus_err = bus_err_q;
  assign halted  = (state_q == ST_HALT);
  assign instret = instret_q;

endmodule
